structure2_fc2_argmax: RTL and testbench
========================================

Name: structure2_fc2_argmax

Overview:
- Downstream of the fc1 stage: consumes the 64 ReLU'd fc1 outputs per group from the fc1 result RAM, once fc1 signals finish.
- Computes OUT_NUM fc2 scores per group (signed 8-bit weights and bias from ROM) and selects the argmax class per group.
- Emits one result per group (class index and winning score) to the result writer / host readout.

Parameters:
- GROUPS, 42, number of groups in fc1 RAM; matches fc1 species.
- IN_NUM, 64, fc1 outputs per group; matches fc1 fc2_num.
- OUT_NUM, 10, fc2 output classes.
- ACC_W, 24, accumulator and score width (signed).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse (fc1 finish rising edge); ignored unless IDLE.
- data_en  out  1  fc1 RAM read enable.
- data_addr  out  14  fc1 RAM address = group*IN_NUM + i.
- data_in  in  8  unsigned fc1 output; valid 1 cycle after data_en.
- w_en  out  1  weight ROM enable; asserted together with data_en.
- w_addr  out  10  weight ROM address = cls*IN_NUM + i.
- w_data  in  8  signed weight; 1-cycle latency.
- b_addr  out  4  bias ROM address = cls.
- b_data  in  8  signed bias; 1-cycle latency.
- result_valid  out  1  one-cycle pulse per group.
- result_group  out  6  group index of the result.
- result_class  out  4  argmax class.
- result_score  out  ACC_W  winning score (signed).
- busy  out  1  high from accepted start until DONE.
- done  out  1  level; set after the last group, cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; counters group=0, cls=0, i=0; acc=0; best_score=0; best_cls=0. Reset mid-run aborts silently with no result_valid.
- FSM states: IDLE, RUN, FLUSH, CMP, EMIT, FIN.
- IDLE: on start go to RUN. Clear group, cls, i, done. Set busy.
- RUN: data_en = w_en = 1 for 64 consecutive cycles, i = 0..63. b_addr = cls throughout. Go to FLUSH after the i=63 issue.
- MAC pipeline:
  - The product for index i lands one cycle after its issue.
  - On the first product (i=0 return), acc is loaded with sext(b_data) + product; the accumulation does not add to the old acc.
  - Every later product is added to acc.
  - product = signed({1'b0,data_in}) * w_data, 17-bit signed, sign-extended to ACC_W. No saturation needed, since 64 * 255 * 128 < 2^23.
- FLUSH: one cycle; absorbs the i=63 product. The fc1 RAM and weight ROM enables are low.
- CMP: one cycle.
  - If cls == 0, or acc > best_score (strict signed compare): best_score <= acc, best_cls <= cls. Ties keep the lower class index.
  - If cls < OUT_NUM-1: cls++, i = 0, go to RUN. Otherwise go to EMIT.
- EMIT: one cycle.
  - result_valid = 1; result_group = group; result_class = best_cls; result_score = best_score.
  - If group < GROUPS-1: group++, cls = 0, go to RUN. Otherwise go to FIN.
- FIN: done <= 1, busy <= 0, go to IDLE. done holds until the next start.
- Timing:
  - Per class: 66 cycles (64 RUN + FLUSH + CMP).
  - Per group: OUT_NUM*66 + 1 cycles.
  - Start to first result_valid: 1 + OUT_NUM*66 cycles = 661 at default.
  - Total: GROUPS*(OUT_NUM*66+1) + 2 cycles.
- Result fields hold their values between pulses. result_valid is strictly a one-cycle pulse.
- start during busy is ignored; it neither restarts nor queues.
- Address arithmetic is constant-multiply plus add. The last address is GROUPS*IN_NUM-1 = 2687, which fits in 14 bits.

Decomposition:
- Shared package (structure2_pkg): GROUPS, IN_NUM, OUT_NUM, ACC_W, the FSM state encoding, and address widths. These are shared with the fc1 stage so RAM sizing stays consistent.
- One natural sub-module: structure2_fc2_mac, covering the registered multiply, the bias-load/accumulate control and the acc register, with inputs first, valid and data/weight.
- The FSM, the address generation and the argmax stay in the top block.

Test Plan:
- Ramp: all data_in = 1, w[cls][i] = cls, b = 0 → each group yields class 9, score 576. First result_valid occurs exactly 661 cycles after start.
- Ties: all weights 0, b[3] = b[7] = 5, other biases 0 → class 3, score 5 for every group (tie resolves to the lower index).
- Negative extremes: data = 255, weights = -128, b = -128 for all classes → class 0, score -2089088. Checks there is no overflow or sign error at ACC_W = 24.
- Full run: random data and ROMs, compared against a reference model → 42 result_valid pulses with groups 0..41 in order. done rises 27764 cycles after start and busy falls at the same time.
- A start pulse mid-run and a second start in IDLE after done → the mid-run start is ignored and produces no extra results. The new start clears done and repeats an identical result sequence.
- rst_n asserted at cycle 300 of group 5 → all outputs go to 0 immediately. A new start after release produces a result for group 0 first.

Source files
------------

// File: rtl/structure2_pkg.sv
// Shared fc1/fc2 sizing and the fc2 sequencer state encoding.
// The fc1 stage imports the same constants so RAM depths stay consistent.
package structure2_pkg;
    localparam int GROUPS  = 42;
    localparam int IN_NUM  = 64;
    localparam int OUT_NUM = 10;
    localparam int ACC_W   = 24;

    localparam int DATA_W      = 8;
    localparam int COEF_W      = 8;
    localparam int DATA_ADDR_W = 14;
    localparam int W_ADDR_W    = 10;
    localparam int B_ADDR_W    = 4;
    localparam int GROUP_W     = 6;
    localparam int CLS_W       = 4;
    localparam int IDX_W       = $clog2(IN_NUM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_CMP,
        ST_EMIT,
        ST_FIN
    } state_t;
endpackage

// File: rtl/structure2_fc2_argmax_if.sv
// fc2 memory read ports (fc1 RAM, weight/bias ROM) and per-group result bus.
interface structure2_fc2_argmax_if;
    import structure2_pkg::*;

    logic                          data_en;
    logic [DATA_ADDR_W-1:0]        data_addr;
    logic [DATA_W-1:0]             data_in;
    logic                          w_en;
    logic [W_ADDR_W-1:0]           w_addr;
    logic signed [COEF_W-1:0]      w_data;
    logic [B_ADDR_W-1:0]           b_addr;
    logic signed [COEF_W-1:0]      b_data;
    logic                          result_valid;
    logic [GROUP_W-1:0]            result_group;
    logic [CLS_W-1:0]              result_class;
    logic signed [ACC_W-1:0]       result_score;

    modport master (
        output data_en, data_addr, w_en, w_addr, b_addr,
        input  data_in, w_data, b_data,
        output result_valid, result_group, result_class, result_score
    );

    modport slave (
        input  data_en, data_addr, w_en, w_addr, b_addr,
        output data_in, w_data, b_data,
        input  result_valid, result_group, result_class, result_score
    );
endinterface

// File: rtl/structure2_fc2_mac.sv
// fc2 multiply-accumulate: unsigned activation x signed weight, bias folded in
// on the first product of each class so acc never needs a separate clear.
module structure2_fc2_mac
    import structure2_pkg::*;
#(
    parameter int DATA_W = structure2_pkg::DATA_W,
    parameter int COEF_W = structure2_pkg::COEF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     first,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic signed [COEF_W-1:0] w_data,
    input  logic signed [COEF_W-1:0] b_data,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PROD_W = DATA_W + COEF_W + 1;

    // 64 * 255 * 128 < 2^23, so the product and sum never need saturation
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic [DATA_W-1:0]        d,
        input logic signed [COEF_W-1:0] w
    );
        logic signed [PROD_W-1:0] d_s;
        logic signed [PROD_W-1:0] w_s;
        d_s = PROD_W'($signed({1'b0, d}));
        w_s = PROD_W'(w);
        return ACC_W'(d_s * w_s);
    endfunction

    logic vld_p1;
    logic first_p1;

    // p0 -> p1: issue flags follow the 1-cycle RAM/ROM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            acc      <= '0;
        end else begin
            vld_p1   <= valid;
            first_p1 <= first;
            if (vld_p1) begin
                if (first_p1) acc <= ACC_W'(b_data) + mac_term(data_in, w_data);
                else          acc <= acc + mac_term(data_in, w_data);
            end
        end
    end
endmodule

// File: rtl/structure2_fc2_argmax.sv
// fc2 layer + argmax: scores OUT_NUM classes per fc1 group and emits the winner.
module structure2_fc2_argmax
    import structure2_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    structure2_fc2_argmax_if.master bus,
    output logic                    busy,
    output logic                    done
);
    localparam logic [GROUP_W-1:0] GROUP_LAST = GROUP_W'(GROUPS - 1);
    localparam logic [CLS_W-1:0]   CLS_LAST   = CLS_W'(OUT_NUM - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(IN_NUM - 1);

    state_t                  state, state_nxt;
    logic [GROUP_W-1:0]      group;
    logic [CLS_W-1:0]        cls;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] best_score, win_score, res_score;
    logic [CLS_W-1:0]        best_cls, win_cls, res_class;
    logic [GROUP_W-1:0]      res_group;
    logic                    run, take;

    always_comb begin
        state_nxt = state;
        run       = (state == ST_RUN);
        // strict compare: a tie keeps the earlier (lower) class
        take      = (cls == '0) || (acc > best_score);
        win_score = take ? acc : best_score;
        win_cls   = take ? cls : best_cls;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (idx == IDX_LAST) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_CMP;
            ST_CMP:   state_nxt = (cls == CLS_LAST) ? ST_EMIT : ST_RUN;
            ST_EMIT:  state_nxt = (group == GROUP_LAST) ? ST_FIN : ST_RUN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            group      <= '0;
            cls        <= '0;
            idx        <= '0;
            best_score <= '0;
            best_cls   <= '0;
            res_group  <= '0;
            res_class  <= '0;
            res_score  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    group <= '0;
                    cls   <= '0;
                    idx   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b1;
                end
                ST_RUN: idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                ST_CMP: begin
                    best_score <= win_score;
                    best_cls   <= win_cls;
                    if (cls != CLS_LAST) begin
                        cls <= cls + CLS_W'(1);
                    end else begin
                        // result fields load here and hold until the next group's last compare
                        res_group <= group;
                        res_class <= win_cls;
                        res_score <= win_score;
                    end
                end
                ST_EMIT: if (group != GROUP_LAST) begin
                    group <= group + GROUP_W'(1);
                    cls   <= '0;
                end
                ST_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_en      = run;
    assign bus.w_en         = run;
    assign bus.data_addr    = DATA_ADDR_W'(group) * DATA_ADDR_W'(IN_NUM) + DATA_ADDR_W'(idx);
    assign bus.w_addr       = W_ADDR_W'(cls) * W_ADDR_W'(IN_NUM) + W_ADDR_W'(idx);
    assign bus.b_addr       = B_ADDR_W'(cls);
    assign bus.result_valid = (state == ST_EMIT);
    assign bus.result_group = res_group;
    assign bus.result_class = res_class;
    assign bus.result_score = res_score;

    structure2_fc2_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .first   (run && (idx == '0)),
        .valid   (run),
        .data_in (bus.data_in),
        .w_data  (bus.w_data),
        .b_data  (bus.b_data),
        .acc     (acc)
    );
endmodule

// File: tb/tb_structure2_fc2_argmax.sv
// Directed bench for the fc2 + argmax stage with behavioural RAM/ROM models.
module tb_structure2_fc2_argmax;
    import structure2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]        ram  [0:GROUPS*IN_NUM-1];
    logic signed [7:0] wrom [0:OUT_NUM*IN_NUM-1];
    logic signed [7:0] brom [0:15];

    structure2_fc2_argmax_if bus ();

    structure2_fc2_argmax dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // memories with one cycle of read latency
    always @(posedge clk) begin
        if (bus.data_en) bus.data_in <= ram[bus.data_addr];
        if (bus.w_en)    bus.w_data  <= wrom[bus.w_addr];
        bus.b_data <= brom[bus.b_addr];
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_group(input int g, output int cls_o, output longint score_o);
        longint s;
        cls_o   = 0;
        score_o = 0;
        for (int c = 0; c < OUT_NUM; c++) begin
            s = longint'(brom[c]);
            for (int i = 0; i < IN_NUM; i++)
                s += longint'({1'b0, ram[g*IN_NUM+i]}) * longint'(wrom[c*IN_NUM+i]);
            if (c == 0 || s > score_o) begin
                score_o = s;
                cls_o   = c;
            end
        end
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "/valid"},     bus.result_valid, 0);
        check({tag, "/group"},     bus.result_group, 0);
        check({tag, "/class"},     bus.result_class, 0);
        check({tag, "/score"},     bus.result_score, 0);
        check({tag, "/busy"},      busy, 0);
        check({tag, "/done"},      done, 0);
        check({tag, "/data_en"},   bus.data_en, 0);
        check({tag, "/w_en"},      bus.w_en, 0);
        check({tag, "/data_addr"}, bus.data_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start cycle counts as cycle 0; cyc is the index of the cycle being observed.
    task automatic run(input string tag, input int n_exp, input bit full, input bit use_hand,
                       input int hand_cls, input longint hand_score,
                       input int mid_at, input int rst_at);
        int     cyc, ngot, mcls;
        longint mscore;
        logic   prev_v;
        bit     seen_done;
        ngot = 0; prev_v = 1'b0; seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        check({tag, "/busy_after_start"}, busy, 1);
        check({tag, "/done_cleared"}, done, 0);
        while (cyc < 30000) begin
            if (rst_at != 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_zero({tag, "/rst"});
                check({tag, "/groups_before_rst"}, ngot, n_exp);
                break;
            end
            if (bus.result_valid) begin
                check({tag, "/valid_pulse"}, prev_v, 0);
                if (ngot == 0) check({tag, "/first_latency"}, cyc, 661);
                check({tag, "/group"}, bus.result_group, ngot);
                if (use_hand) begin
                    check({tag, "/class"}, bus.result_class, hand_cls);
                    check({tag, "/score"}, bus.result_score, hand_score);
                end else begin
                    model_group(ngot, mcls, mscore);
                    check({tag, "/class"}, bus.result_class, mcls);
                    check({tag, "/score"}, bus.result_score, mscore);
                end
                ngot++;
            end
            prev_v = bus.result_valid;
            if (done) begin
                check({tag, "/done_cycle"}, cyc, 27764);
                check({tag, "/busy_at_done"}, busy, 0);
                seen_done = 1'b1;
                break;
            end
            if (!full && rst_at == 0 && ngot == n_exp) break;
            start = (mid_at != 0 && cyc == mid_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (rst_at == 0) check({tag, "/result_count"}, ngot, n_exp);
        if (full) check({tag, "/done_seen"}, seen_done, 1);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) brom[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ramp: data 1, weight = class index, no bias -> class 9 wins with 64*9
        for (int k = 0; k < GROUPS*IN_NUM; k++) ram[k] = 8'd1;
        for (int c = 0; c < OUT_NUM; c++)
            for (int i = 0; i < IN_NUM; i++) wrom[c*IN_NUM+i] = 8'(c);
        run("ramp", 2, 1'b0, 1'b1, 9, 576, 0, 0);
        do_reset();

        // ties: only biases 3 and 7 are nonzero and equal -> lower index wins
        for (int k = 0; k < OUT_NUM*IN_NUM; k++) wrom[k] = '0;
        brom[3] = 8'sd5;
        brom[7] = 8'sd5;
        run("ties", 2, 1'b0, 1'b1, 3, 5, 0, 0);
        do_reset();

        // negative extremes: 64*255*(-128) - 128 for every class
        for (int k = 0; k < GROUPS*IN_NUM; k++) ram[k] = 8'd255;
        for (int k = 0; k < OUT_NUM*IN_NUM; k++) wrom[k] = -8'sd128;
        for (int k = 0; k < OUT_NUM; k++) brom[k] = -8'sd128;
        run("neg", 2, 1'b0, 1'b1, 0, -2089088, 0, 0);
        do_reset();

        for (int k = 0; k < GROUPS*IN_NUM; k++) ram[k] = 8'($urandom);
        for (int k = 0; k < OUT_NUM*IN_NUM; k++) wrom[k] = 8'($urandom);
        for (int k = 0; k < 16; k++) brom[k] = 8'($urandom);
        run("full", GROUPS, 1'b1, 1'b0, 0, 0, 1000, 0);
        repeat (5) @(posedge clk);
        #1;
        check("idle_done_level", done, 1);
        check("idle_busy_low", busy, 0);

        run("rerun", GROUPS, 1'b1, 1'b0, 0, 0, 0, 0);

        // group 5 begins at cycle 3306; abort 300 cycles into it
        run("rst_mid", 5, 1'b0, 1'b0, 0, 0, 0, 3606);
        @(negedge clk);
        rst_n = 1'b1;
        run("rst_restart", 1, 1'b0, 1'b0, 0, 0, 0, 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
